// File: rtl/arm_pkg.sv
// Shared ARM register-file constants and the pending-counter width helper.
package arm_pkg;

    localparam int REG_COUNT            = 16;
    localparam int REG_ADDR_W           = 4;
    localparam int DEFAULT_WORD_LENGTH  = 32;
    localparam int DEFAULT_MAX_INFLIGHT = 3;

    function automatic int pend_width(input int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

endpackage

// File: rtl/pending_counter.sv
// Saturating count of issued-but-unretired writes for one register.
module pending_counter #(
    parameter int MAX_INFLIGHT = 3,
    parameter int W            = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         nonzero,
    output logic         err
);

    logic at_max;
    logic at_zero;

    assign at_max  = (count == W'(MAX_INFLIGHT));
    assign at_zero = (count == '0);
    assign nonzero = !at_zero;
    // Out-of-range moves hold the count and only report the error.
    assign err = (inc && !dec && at_max) || (dec && !inc && at_zero);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && !at_max) begin
            count <= count + W'(1);
        end else if (dec && !inc && !at_zero) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/reg_file_scoreboard.sv
// 16x32 register file with WB bypass and per-register pending-write scoreboard.
module reg_file_scoreboard
    import arm_pkg::*;
#(
    parameter int WORD_LENGTH  = DEFAULT_WORD_LENGTH,
    parameter int MAX_INFLIGHT = DEFAULT_MAX_INFLIGHT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_ADDR_W-1:0]  src1,
    input  logic [REG_ADDR_W-1:0]  src2,
    input  logic                   two_src,
    output logic [WORD_LENGTH-1:0] reg1,
    output logic [WORD_LENGTH-1:0] reg2,
    input  logic                   issue_valid,
    input  logic                   issue_wb_en,
    input  logic [REG_ADDR_W-1:0]  issue_dest,
    input  logic                   wb_enable,
    input  logic [REG_ADDR_W-1:0]  wb_dest,
    input  logic [WORD_LENGTH-1:0] wb_value,
    output logic                   hazard,
    output logic                   sb_error
);

    localparam int PW = pend_width(MAX_INFLIGHT);

    logic [WORD_LENGTH-1:0] regs [REG_COUNT];
    logic [PW-1:0]          count [REG_COUNT];
    logic [REG_COUNT-1:0]   inc_v;
    logic [REG_COUNT-1:0]   dec_v;
    logic [REG_COUNT-1:0]   nz_v;
    logic [REG_COUNT-1:0]   err_v;
    logic [REG_COUNT-1:0]   busy_v;
    logic                   acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < REG_COUNT; r++) regs[r] <= '0;
        end else if (wb_enable) begin
            regs[wb_dest] <= wb_value;
        end
    end

    assign reg1 = dec_v[src1] ? wb_value : regs[src1];
    assign reg2 = dec_v[src2] ? wb_value : regs[src2];

    assign hazard = busy_v[src1] || (two_src && busy_v[src2]);
    assign acc    = issue_valid && issue_wb_en && !hazard;

    for (genvar r = 0; r < REG_COUNT; r++) begin : g_pend
        assign dec_v[r] = wb_enable && (wb_dest == REG_ADDR_W'(r));
        assign inc_v[r] = acc && (issue_dest == REG_ADDR_W'(r));
        // A retiring write removes itself from the hazard in its own cycle.
        assign busy_v[r] = dec_v[r] ? (count[r] != PW'(1)) : nz_v[r];

        pending_counter #(
            .MAX_INFLIGHT(MAX_INFLIGHT),
            .W           (PW)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc    (inc_v[r]),
            .dec    (dec_v[r]),
            .count  (count[r]),
            .nonzero(nz_v[r]),
            .err    (err_v[r])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_error <= 1'b0;
        end else if (|err_v) begin
            sb_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench: driver predicts from a behavioural model, monitor compares.
module tb_reg_file_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  src1 = '0, src2 = '0, issue_dest = '0, wb_dest = '0;
    logic        two_src = 1'b0, issue_valid = 1'b0, issue_wb_en = 1'b0;
    logic        wb_enable = 1'b0;
    logic [31:0] wb_value = '0;
    logic [31:0] reg1, reg2;
    logic        hazard, sb_error;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [3:0]  s1, s2;
        logic        two, iv, iwe;
        logic [3:0]  id;
        logic        wbe;
        logic [3:0]  wd;
        logic [31:0] wv;
    } stim_t;

    typedef struct packed {
        logic [31:0] r1, r2;
        logic        hz, err;
    } exp_t;

    exp_t        q[$];
    int          pend [16];
    logic [31:0] mregs [16];
    bit          merr;

    reg_file_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .src1       (src1),
        .src2       (src2),
        .two_src    (two_src),
        .reg1       (reg1),
        .reg2       (reg2),
        .issue_valid(issue_valid),
        .issue_wb_en(issue_wb_en),
        .issue_dest (issue_dest),
        .wb_enable  (wb_enable),
        .wb_dest    (wb_dest),
        .wb_value   (wb_value),
        .hazard     (hazard),
        .sb_error   (sb_error)
    );

    always #5 clk = ~clk;

    function automatic int eff(input int r, input stim_t s);
        return pend[r] - ((s.wbe && s.wd == 4'(r)) ? 1 : 0);
    endfunction

    function automatic exp_t predict(input stim_t s);
        exp_t e;
        e.r1  = (s.wbe && s.wd == s.s1) ? s.wv : mregs[s.s1];
        e.r2  = (s.wbe && s.wd == s.s2) ? s.wv : mregs[s.s2];
        e.hz  = (eff(s.s1, s) != 0) || (s.two && eff(s.s2, s) != 0);
        e.err = merr;
        return e;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 16; r++) begin
            pend[r]  = 0;
            mregs[r] = '0;
        end
        merr = 1'b0;
    endtask

    task automatic model_step(input stim_t s);
        exp_t e;
        bit   acc;
        e   = predict(s);
        acc = s.iv && s.iwe && !e.hz;
        for (int r = 0; r < 16; r++) begin
            bit inc, dec;
            inc = acc && s.id == 4'(r);
            dec = s.wbe && s.wd == 4'(r);
            if (inc && !dec) begin
                if (pend[r] == 3) merr = 1'b1;
                else pend[r]++;
            end else if (dec && !inc) begin
                if (pend[r] == 0) merr = 1'b1;
                else pend[r]--;
            end
        end
        if (s.wbe) mregs[s.wd] = s.wv;
    endtask

    task automatic drive(input stim_t s);
        src1 = s.s1; src2 = s.s2; two_src = s.two;
        issue_valid = s.iv; issue_wb_en = s.iwe; issue_dest = s.id;
        wb_enable = s.wbe; wb_dest = s.wd; wb_value = s.wv;
    endtask

    task automatic apply(input stim_t s);
        @(negedge clk);
        drive(s);
        #1 q.push_back(predict(s));
        @(posedge clk);
        model_step(s);
    endtask

    task automatic do_reset(input logic [3:0] probe);
        stim_t s;
        s = '0;
        s.s1 = probe;
        s.s2 = probe ^ 4'h5;
        @(negedge clk);
        drive(s);
        rst = 1'b1;
        model_clear();
        #1 q.push_back(predict(s));
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    function automatic stim_t mk(input logic [3:0] s1, input logic [3:0] s2,
                                 input logic two, input logic iv,
                                 input logic [3:0] id, input logic wbe,
                                 input logic [3:0] wd, input logic [31:0] wv);
        stim_t s;
        s.s1 = s1; s.s2 = s2; s.two = two; s.iv = iv; s.iwe = iv; s.id = id;
        s.wbe = wbe; s.wd = wd; s.wv = wv;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("reg1", reg1, e.r1);
                chk("reg2", reg2, e.r2);
                chk("hazard", 32'(hazard), 32'(e.hz));
                chk("sb_error", 32'(sb_error), 32'(e.err));
            end
        end
    end

    initial begin : driver
        stim_t s;
        model_clear();
        rst = 1'b1;
        #12 rst = 1'b0;

        apply(mk(4'd3, 4'd7, 1, 0, 0, 0, 0, 0));
        apply(mk(4'd5, 4'd0, 0, 0, 0, 1, 4'd5, 32'hDEADBEEF));
        apply(mk(4'd5, 4'd0, 0, 0, 0, 0, 0, 0));

        apply(mk(4'd0, 4'd0, 0, 1, 4'd2, 0, 0, 0));
        apply(mk(4'd2, 4'd0, 0, 0, 0, 0, 0, 0));
        apply(mk(4'd2, 4'd0, 0, 0, 0, 0, 0, 0));
        apply(mk(4'd2, 4'd0, 0, 0, 0, 1, 4'd2, 32'h1234_5678));

        apply(mk(4'd0, 4'd0, 0, 1, 4'd6, 0, 0, 0));
        apply(mk(4'd0, 4'd6, 0, 0, 0, 0, 0, 0));
        apply(mk(4'd0, 4'd6, 1, 1, 4'd8, 0, 0, 0));
        apply(mk(4'd8, 4'd6, 1, 0, 0, 1, 4'd6, 32'hA5A5_0006));
        apply(mk(4'd8, 4'd6, 1, 0, 0, 0, 0, 0));

        apply(mk(4'd0, 4'd0, 0, 1, 4'd4, 0, 0, 0));
        apply(mk(4'd0, 4'd0, 0, 1, 4'd4, 1, 4'd4, 32'h0000_0044));
        apply(mk(4'd4, 4'd0, 0, 0, 0, 0, 0, 0));
        apply(mk(4'd4, 4'd0, 0, 0, 0, 1, 4'd4, 32'h0000_0444));
        apply(mk(4'd4, 4'd0, 0, 0, 0, 0, 0, 0));

        apply(mk(4'd0, 4'd0, 0, 0, 0, 1, 4'd9, 32'h9999_0009));
        apply(mk(4'd9, 4'd0, 0, 0, 0, 0, 0, 0));
        do_reset(4'd9);
        for (int i = 0; i < 4; i++) apply(mk(4'd0, 4'd0, 0, 1, 4'd1, 0, 0, 0));
        apply(mk(4'd1, 4'd0, 0, 0, 0, 1, 4'd1, 32'h0101_0101));
        apply(mk(4'd1, 4'd0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 800; i++) begin
            if (i % 80 == 79) begin
                do_reset(4'($urandom_range(0, 15)));
            end else begin
                logic [31:0] rv;
                rv = $urandom();
                s.s1  = 4'(rv[3:0]);
                s.s2  = 4'(rv[7:4]);
                s.id  = 4'(rv[11:8]);
                s.wd  = 4'(rv[15:12]);
                if (i % 160 < 80) begin
                    s.s1 &= 4'h3; s.s2 &= 4'h3;
                    s.id &= 4'h3; s.wd &= 4'h3;
                end
                s.two = rv[16];
                s.iv  = rv[17] | rv[18];
                s.iwe = rv[19] | rv[20];
                s.wbe = rv[21] & rv[22];
                s.wv  = $urandom();
                apply(s);
            end
        end

        @(negedge clk);
        drive('0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
